conv3x3_stream: RTL and testbench
=================================

Name: conv3x3_stream

Overview:
- Streaming 3x3 image convolution engine, next generation of the team's fixed-window conv block.
- Takes one raster-order pixel stream and builds the 3x3 window internally using two on-chip line buffers sized by MAX_WIDTH; image width is set at runtime.
- Valid/ready handshakes on both sides; applies one of four kernels; emits the (W-2)x(H-2) interior output image with frame and line markers.
- Sits between the pixel source (camera/DMA) and downstream filter or writeback stages.

Parameters:
- PIXEL_WIDTH, 8, bits per unsigned pixel.
- MAX_WIDTH, 640, maximum image width in pixels; sets the depth of each line buffer.
- COL_WIDTH, 10, width of the column counter and of img_width; must satisfy 2^COL_WIDTH > MAX_WIDTH.
- ACC_WIDTH, 16, signed accumulator width; must be at least PIXEL_WIDTH+5.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: reset, synchronous, active-low; clock clk.
- img_width, in, COL_WIDTH: active image width W; sampled on the sof beat.
- mode, in, 2: 0 = sharpen, 1 = gaussian, 2 = edge, 3 = pass-through; sampled on the sof beat.
- in_valid, in, 1: input pixel valid.
- in_ready, out, 1: block can accept a pixel.
- in_pixel, in, PIXEL_WIDTH: unsigned pixel.
- in_sof, in, 1: marks the first pixel of a frame, at row 0, col 0.
- out_valid, out, 1: output pixel valid.
- out_ready, in, 1: downstream accepts.
- out_pixel, out, PIXEL_WIDTH: saturated result.
- out_sof, out, 1: first interior output of the frame.
- out_eol, out, 1: last interior output of the row.

Behaviour:
- Reset: out_valid=0, out_pixel=0, out_sof=0, out_eol=0. Row and column counters are 0. Latched width and mode are 0. Line buffer contents are not cleared.
- A beat transfers when in_valid & in_ready. in_ready = !out_valid | out_ready, so the single output register never drops data.
- On each accepted beat:
  - Write the pixel into line buffer 1 at column col.
  - Move the old line buffer 1 entry at col into line buffer 0.
  - Shift a 3-column window register using the old line buffer 0 entry (top), the old line buffer 1 entry (middle) and the new pixel (bottom).
- in_sof beat:
  - Forces row=0 and col=0 for this pixel.
  - Latches img_width and mode; these stay frame-stable.
  - Any pending output still drains normally.
- Counters:
  - col increments per beat and wraps to 0 after W-1, which increments row.
  - row saturates at its maximum; there is no height parameter.
  - The frame ends implicitly at the next sof.
- Output: when the accepted pixel has row>=2 and col>=2, the window centred at (row-1, col-1) is computed and registered.
  - Latency is 1 cycle: out_valid rises the cycle after the accepting edge.
  - Output pixel (r-1, c-1) follows input beat (r, c).
  - out_sof = (row==2 & col==2); out_eol = (col==W-1).
  - out_valid clears when out_ready is high and no new result is loaded that cycle.
  - Under backpressure, out_pixel, out_sof and out_eol hold stable.
- Arithmetic: operands are zero-extended to ACC_WIDTH signed.
  - Sharpen: 5*c - n - s - e - w.
  - Gaussian: (corners + 2*edges + 4*centre) >>> 4, which floors because the sum is nonnegative.
  - Edge: 8*c - (sum of the 8 neighbours).
  - Pass-through: centre pixel.
  - All results saturate: <0 gives 0, >2^PIXEL_WIDTH-1 gives all ones.
- Boundaries:
  - W<3 or W>MAX_WIDTH: no outputs are produced for the frame; the input is still accepted.
  - W=3 gives one output per row from row 2 on.
  - in_valid low stalls everything with no state change.
  - A sof arriving mid-row restarts counters without emitting output for the partial row.
- Reset mid-frame: the output register is cleared immediately. Input is ignored until the next sof.

Test Plan:
- W=5, mode 1, 4 rows of constant 100: 6 outputs of 100; out_sof on the first, out_eol on the 3rd and 6th.
- W=4, mode 2, 3 rows all 0 except pixel (1,1)=200: outputs 255, 0 (1600 saturates high, -200 saturates low).
- W=4, mode 0, 3 rows all 10 except centre (1,1)=50: outputs 210 and 0 (250-40=210; 10*5-50-30=-30 gives 0).
- Backpressure: W=5, mode 3, out_ready toggled 1-0-0-1 during streaming.
  - in_ready falls while the output is held.
  - out_pixel stays stable.
  - All 6 pass-through values arrive in order with none lost or duplicated.
- W=2 frame, then a W=3 frame via sof: no outputs for the first; the second yields an output after the beat at (2,2).
- rst_n low for 1 cycle mid-frame with out_valid=1: out_valid=0 next cycle; no outputs until after a fresh sof and row 2.

Source files
------------

// File: rtl/conv3x3_stream_if.sv
// Pixel stream bundle for conv3x3_stream: input beats in, interior
// results out, each side with its own valid/ready handshake.
interface conv3x3_stream_if #(
   parameter int PIXEL_WIDTH = 8
);
   logic                   in_valid;
   logic                   in_ready;
   logic [PIXEL_WIDTH-1:0] in_pixel;
   logic                   in_sof;
   logic                   out_valid;
   logic                   out_ready;
   logic [PIXEL_WIDTH-1:0] out_pixel;
   logic                   out_sof;
   logic                   out_eol;

   modport master (
      output in_valid, in_pixel, in_sof, out_ready,
      input  in_ready, out_valid, out_pixel, out_sof, out_eol
   );

   modport slave (
      input  in_valid, in_pixel, in_sof, out_ready,
      output in_ready, out_valid, out_pixel, out_sof, out_eol
   );
endinterface

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution: two line buffers build the window from a
// raster pixel stream; one registered, saturated result per interior pixel.
module conv3x3_stream #(
   parameter int PIXEL_WIDTH = 8,
   parameter int MAX_WIDTH   = 640,
   parameter int COL_WIDTH   = 10,
   parameter int ACC_WIDTH   = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [COL_WIDTH-1:0] img_width,
   input  logic [1:0]           mode,
   conv3x3_stream_if.slave      bus
);

   localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

   localparam logic [COL_WIDTH-1:0] MAX_W = COL_WIDTH'(MAX_WIDTH);
   localparam logic [COL_WIDTH-1:0] ONE   = COL_WIDTH'(1);
   localparam logic [COL_WIDTH-1:0] TWO   = COL_WIDTH'(2);
   localparam logic [COL_WIDTH-1:0] THREE = COL_WIDTH'(3);

   typedef logic [PIXEL_WIDTH-1:0]      pix_t;
   typedef logic signed [ACC_WIDTH-1:0] acc_t;

   localparam acc_t PIX_MAX = ACC_WIDTH'((1 << PIXEL_WIDTH) - 1);

   function automatic acc_t ext(input pix_t p);
      return $signed({{(ACC_WIDTH-PIXEL_WIDTH){1'b0}}, p});
   endfunction

   function automatic pix_t sat(input acc_t v);
      if (v[ACC_WIDTH-1])
         return '0;
      else if (v > PIX_MAX)
         return '1;
      else
         return v[PIXEL_WIDTH-1:0];
   endfunction

   pix_t lb0 [MAX_WIDTH];
   pix_t lb1 [MAX_WIDTH];

   // index 0 = column col-2, index 1 = column col-1
   pix_t wt [2];
   pix_t wm [2];
   pix_t wb [2];

   logic [COL_WIDTH-1:0] col_q;
   logic [1:0]           row_q;
   logic [COL_WIDTH-1:0] width_q;
   logic [1:0]           mode_q;
   logic                 armed_q;

   logic out_valid_q;
   pix_t out_pixel_q;
   logic out_sof_q;
   logic out_eol_q;

   logic                 fire;
   logic                 beat;
   logic                 load;
   logic                 w_ok;
   logic                 last_col;
   logic [COL_WIDTH-1:0] cur_col;
   logic [1:0]           cur_row;
   logic [COL_WIDTH-1:0] eff_w;
   logic [AW-1:0]        addr;
   pix_t                 top_n;
   pix_t                 mid_n;
   acc_t                 acc;

   assign bus.in_ready  = !out_valid_q | bus.out_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_pixel = out_pixel_q;
   assign bus.out_sof   = out_sof_q;
   assign bus.out_eol   = out_eol_q;

   // beats before the first sof after reset are swallowed
   assign fire     = bus.in_valid & bus.in_ready;
   assign beat     = fire & (bus.in_sof | armed_q);
   assign cur_col  = bus.in_sof ? '0 : col_q;
   assign cur_row  = bus.in_sof ? '0 : row_q;
   assign eff_w    = bus.in_sof ? img_width : width_q;
   assign last_col = (cur_col == eff_w - ONE);
   assign addr     = cur_col[AW-1:0];
   assign top_n    = lb0[addr];
   assign mid_n    = lb1[addr];
   assign w_ok     = (width_q >= THREE) && (width_q <= MAX_W);
   assign load     = beat & w_ok & cur_row[1] & (cur_col >= TWO);

   always_comb begin
      acc_t c;
      acc_t edges;
      acc_t corners;
      acc = '0;
      c = ext(wm[1]);
      edges = ext(wt[1]) + ext(wb[1])
            + ext(wm[0]) + ext(mid_n);
      corners = ext(wt[0]) + ext(wb[0])
              + ext(top_n) + ext(bus.in_pixel);
      unique case (mode_q)
         2'd0: acc = (c <<< 2) + c - edges;
         2'd1: acc = (corners + (edges <<< 1)
                      + (c <<< 2)) >>> 4;
         2'd2: acc = (c <<< 3) - edges - corners;
         2'd3: acc = c;
      endcase
   end

   always_ff @(posedge clk) begin
      if (beat) begin
         if (cur_col < MAX_W) begin
            lb0[addr] <= mid_n;
            lb1[addr] <= bus.in_pixel;
         end
         wt[0] <= wt[1];
         wt[1] <= top_n;
         wm[0] <= wm[1];
         wm[1] <= mid_n;
         wb[0] <= wb[1];
         wb[1] <= bus.in_pixel;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         col_q       <= '0;
         row_q       <= '0;
         width_q     <= '0;
         mode_q      <= '0;
         armed_q     <= 1'b0;
         out_valid_q <= 1'b0;
         out_pixel_q <= '0;
         out_sof_q   <= 1'b0;
         out_eol_q   <= 1'b0;
      end else begin
         if (beat) begin
            if (bus.in_sof) begin
               width_q <= img_width;
               mode_q  <= mode;
               armed_q <= 1'b1;
            end
            if (last_col) begin
               col_q <= '0;
               row_q <= (cur_row == 2'd3) ? cur_row
                                          : cur_row + 2'd1;
            end else begin
               col_q <= cur_col + ONE;
               row_q <= cur_row;
            end
         end
         if (load) begin
            out_valid_q <= 1'b1;
            out_pixel_q <= sat(acc);
            out_sof_q   <= (cur_row == 2'd2) && (cur_col == TWO);
            out_eol_q   <= last_col;
         end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_conv3x3_stream.sv
// Scoreboard bench for conv3x3_stream: a reference convolution of the
// driven image predicts every interior output and its markers.
module tb_conv3x3_stream;

   localparam int PW = 8;
   localparam int MW = 16;
   localparam int CW = 10;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [CW-1:0] img_width;
   logic [1:0]    mode;

   conv3x3_stream_if #(.PIXEL_WIDTH(PW)) bus ();

   conv3x3_stream #(
      .PIXEL_WIDTH(PW),
      .MAX_WIDTH  (MW),
      .COL_WIDTH  (CW),
      .ACC_WIDTH  (16)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .img_width(img_width),
      .mode     (mode),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int px;
      int sof;
      int eol;
   } exp_t;

   exp_t sb [$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_rx    = 0;
   int   bp_seen = 0;
   int   img [0:7][0:19];

   logic       force_stall = 1'b0;
   logic       bp_en = 1'b0;
   int         bp_k = 0;
   logic [3:0] bp_pat = 4'b1001;

   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int sat8(input int v);
      return (v < 0) ? 0 : ((v > 255) ? 255 : v);
   endfunction

   function automatic int conv_ref(input int r, input int c, input int md);
      int ce = img[r][c];
      int ed = img[r-1][c] + img[r+1][c] + img[r][c-1] + img[r][c+1];
      int co = img[r-1][c-1] + img[r-1][c+1]
             + img[r+1][c-1] + img[r+1][c+1];
      case (md)
         0:       return sat8(5*ce - ed);
         1:       return sat8((co + 2*ed + 4*ce) / 16);
         2:       return sat8(8*ce - ed - co);
         default: return ce;
      endcase
   endfunction

   // out_ready driver
   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (force_stall)
            bus.out_ready = 1'b0;
         else if (bp_en) begin
            bus.out_ready = bp_pat[2'(bp_k)];
            bp_k++;
         end else
            bus.out_ready = 1'b1;
      end
   end

   // output monitor and scoreboard compare
   initial begin
      logic hold_v;
      int   hold_px;
      int   hold_s;
      int   hold_e;
      exp_t e;
      hold_v = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n && bus.out_valid) begin
            if (hold_v) begin
               chk("hold_px", int'(bus.out_pixel), hold_px);
               chk("hold_sof", int'(bus.out_sof), hold_s);
               chk("hold_eol", int'(bus.out_eol), hold_e);
            end
            if (bus.out_ready) begin
               hold_v = 1'b0;
               n_rx++;
               if (sb.size() == 0)
                  chk("spurious", int'(bus.out_valid), 0);
               else begin
                  e = sb.pop_front();
                  chk("px", int'(bus.out_pixel), e.px);
                  chk("sof", int'(bus.out_sof), e.sof);
                  chk("eol", int'(bus.out_eol), e.eol);
               end
            end else begin
               if (!hold_v) bp_seen++;
               chk("in_rdy_bp", int'(bus.in_ready), 0);
               hold_v  = 1'b1;
               hold_px = int'(bus.out_pixel);
               hold_s  = int'(bus.out_sof);
               hold_e  = int'(bus.out_eol);
            end
         end else
            hold_v = 1'b0;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: sim time exceeded");
      $fatal(1, "watchdog");
   end

   task automatic put_pix(input int px, input logic sof, output logic ok);
      bus.in_valid = 1'b1;
      bus.in_pixel = px[7:0];
      bus.in_sof   = sof;
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         ok = bus.in_ready;
      end
      if (!ok) chk("acc_timeout", int'(bus.in_ready), 1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_sof   = 1'b0;
   endtask

   task automatic run_frame(input int w, input int h, input int md,
                            input int max_beats, input bit gaps);
      logic ok;
      exp_t e;
      int   nb = 0;
      img_width = CW'(w);
      mode      = 2'(md);
      for (int r = 0; r < h; r++) begin
         for (int c = 0; c < w; c++) begin
            if (max_beats < 0 || nb < max_beats) begin
               put_pix(img[r][c], (r == 0 && c == 0), ok);
               nb++;
               if (ok && w >= 3 && w <= MW && r >= 2 && c >= 2) begin
                  e.px  = conv_ref(r-1, c-1, md);
                  e.sof = (r == 2 && c == 2) ? 1 : 0;
                  e.eol = (c == w-1) ? 1 : 0;
                  sb.push_back(e);
               end
               if (gaps && $urandom_range(0, 3) == 0) begin
                  @(posedge clk);
                  #1;
               end
            end
         end
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && sb.size() != 0; i++)
         @(posedge clk);
      repeat (3) @(posedge clk);
      #1;
      chk("drain", sb.size(), 0);
   endtask

   task automatic fill_const(input int v);
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 20; c++)
            img[r][c] = v;
   endtask

   task automatic fill_rand();
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 20; c++)
            img[r][c] = int'($urandom_range(0, 255));
   endtask

   initial begin
      int   base;
      logic ok;
      bus.in_valid = 1'b0;
      bus.in_pixel = '0;
      bus.in_sof   = 1'b0;
      img_width    = '0;
      mode         = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", int'(bus.out_valid), 0);
      chk("rst_pixel", int'(bus.out_pixel), 0);
      chk("rst_sof", int'(bus.out_sof), 0);
      chk("rst_eol", int'(bus.out_eol), 0);
      chk("rst_in_ready", int'(bus.in_ready), 1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // constant gaussian
      fill_const(100);
      base = n_rx;
      run_frame(5, 4, 1, -1, 1'b0);
      drain();
      chk("gauss_n", n_rx - base, 6);

      // edge with single bright pixel
      fill_const(0);
      img[1][1] = 200;
      base = n_rx;
      run_frame(4, 3, 2, -1, 1'b0);
      drain();
      chk("edge_n", n_rx - base, 2);

      // sharpen
      fill_const(10);
      img[1][1] = 50;
      base = n_rx;
      run_frame(4, 3, 0, -1, 1'b0);
      drain();
      chk("sharp_n", n_rx - base, 2);

      // backpressure on pass-through
      fill_rand();
      bp_en = 1'b1;
      bp_seen = 0;
      base = n_rx;
      run_frame(5, 4, 3, -1, 1'b0);
      drain();
      bp_en = 1'b0;
      chk("bp_n", n_rx - base, 6);
      chk("bp_seen", (bp_seen > 0) ? 1 : 0, 1);

      // too narrow, then minimum width
      fill_rand();
      base = n_rx;
      run_frame(2, 3, 3, -1, 1'b0);
      drain();
      chk("w2_n", n_rx - base, 0);
      base = n_rx;
      run_frame(3, 3, 3, -1, 1'b0);
      drain();
      chk("w3_n", n_rx - base, 1);

      // too wide, then full line buffer width
      fill_rand();
      base = n_rx;
      run_frame(MW + 1, 3, 3, -1, 1'b0);
      drain();
      chk("wide_n", n_rx - base, 0);
      fill_rand();
      base = n_rx;
      run_frame(MW, 3, 2, -1, 1'b0);
      drain();
      chk("wmax_n", n_rx - base, MW - 2);

      // sof mid-row restarts the frame
      fill_rand();
      base = n_rx;
      run_frame(5, 4, 3, 13, 1'b0);
      fill_rand();
      run_frame(5, 3, 0, -1, 1'b0);
      drain();
      chk("midsof_n", n_rx - base, 4);

      // all kernels on random images with input gaps
      for (int m = 0; m < 4; m++) begin
         fill_rand();
         base = n_rx;
         run_frame(6, 5, m, -1, 1'b1);
         drain();
         chk("rand_n", n_rx - base, 12);
      end

      // reset while an output is held
      @(posedge clk);
      #1;
      force_stall = 1'b1;
      @(posedge clk);
      #1;
      fill_rand();
      run_frame(5, 4, 3, 13, 1'b0);
      @(negedge clk);
      chk("rst_pre", int'(bus.out_valid), 1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      sb.delete();
      force_stall = 1'b0;
      @(negedge clk);
      chk("rst_clr", int'(bus.out_valid), 0);
      base = n_rx;
      for (int i = 0; i < 15; i++)
         put_pix(int'($urandom_range(0, 255)), 1'b0, ok);
      repeat (4) @(posedge clk);
      #1;
      chk("rst_quiet", n_rx - base, 0);
      fill_rand();
      base = n_rx;
      run_frame(3, 3, 1, -1, 1'b0);
      drain();
      chk("rst_resume", n_rx - base, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
